range_sample_framer: RTL and testbench
======================================

Name: range_sample_framer

Overview:
Upstream feeder for the 16-bit range finder stage. Accepts a byte stream with start-of-frame and end-of-frame sideband flags. Assembles little-endian sample words and drives the range finder's data/go/finish inputs with correct framing. Detects malformed frames and timeouts, and forces the downstream stage into its error state by pulsing go and finish together.

Parameters:
WIDTH, 16, sample width; must be 16 (two bytes per sample)
TIMEOUT, 255, max idle cycles between bytes inside a frame before abort
CNT_W, 16, width of sample_count

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
byte_in  in  8  stream byte
byte_valid  in  1  byte_in/flags valid; a transfer occurs when byte_valid & byte_ready
byte_sof  in  1  first byte of frame (qualified by transfer)
byte_eof  in  1  last byte of frame (qualified by transfer)
byte_ready  out  1  framer can accept a byte this cycle
data_out  out  WIDTH  assembled sample, registered, held between samples
go  out  1  one-cycle pulse: first sample of frame on data_out
finish  out  1  one-cycle pulse: last sample of frame on data_out
frame_err  out  1  one-cycle pulse on any framing fault
sample_count  out  CNT_W  samples emitted in current/last frame, saturating

Behaviour:
- Reset: state IDLE; data_out=0, go=0, finish=0, frame_err=0, sample_count=0, byte_ready=1, timeout counter=0. Reset mid-frame discards the partial frame without emitting a pulse.
- All outputs except byte_ready are registered. A sample appears on data_out one cycle after its high-byte transfer.
- Byte order: first byte = bits [7:0], second = bits [15:8].
- byte_ready=1 in all states except FLUSH.
- States: IDLE, HIGH, LOW, FLUSH. A "first" flag marks the first sample of the frame.
- IDLE:
  - Transfer with sof: latch low byte, set first, go to HIGH.
  - Transfer without sof: drop the byte, pulse frame_err, stay in IDLE.
- HIGH (transfer):
  - Without sof: data_out <= {byte_in, low}, sample_count+1.
    - If first and eof: pulse go, go to FLUSH.
    - Else if first: pulse go, clear first, go to LOW.
    - Else if eof: pulse finish, go to IDLE.
    - Else go to LOW.
- LOW (transfer):
  - Without sof and without eof: latch low byte, go to HIGH.
  - With eof (odd byte count): pulse frame_err and abort.
- FLUSH: pulse finish with data_out unchanged, go to IDLE. Single-sample frames therefore produce go and finish on consecutive cycles, never together.
- Abort (HIGH/LOW only):
  - Triggers: sof in HIGH/LOW, eof on a low byte, or timeout.
  - Action: pulse frame_err, and pulse go=1 and finish=1 simultaneously for one cycle (downstream error encoding).
  - Next state: if the trigger byte carried sof, it restarts a frame: latch low, set first, go to HIGH, sample_count=0. Otherwise go to IDLE.
- Timeout: the counter runs in HIGH/LOW and clears on any transfer. When it reaches TIMEOUT with no transfer, abort.
- sample_count clears on a frame-opening sof and saturates at all-ones.
- go, finish and frame_err are each single-cycle. go&finish together occurs only on abort.
- byte_valid while byte_ready=0 is ignored; the source holds the byte.

Decomposition:
- Shared package range_pkg: state enum (IDLE, HIGH, LOW, FLUSH), BYTE_W=8, default WIDTH/TIMEOUT constants.
- One sub-module: range_idle_timer, a loadable down-counter with a clear-on-transfer input and an expired flag.

Test Plan:
- Frame 0x34,0x12 (sof), 0x78,0x56, 0xBC,0x9A (eof), back-to-back -> data_out 0x1234 with go, 0x5678, then 0x9ABC with finish; sample_count=3; no frame_err.
- Single sample 0x01(sof), 0x00(eof) -> data_out=0x0001 with go; next cycle finish with data_out held at 0x0001; byte_ready=0 for exactly that one cycle.
- sof byte arriving in LOW after one sample -> frame_err plus go&finish together for one cycle; new frame starts from that byte; sample_count resets to 0.
- eof on a low byte (3-byte frame) -> frame_err, go&finish abort pulse, state IDLE; the odd byte never appears on data_out.
- TIMEOUT=4, stall after a low byte -> abort pulse on the 5th idle cycle; stray non-sof byte in IDLE -> frame_err only, no go/finish.
- Assert reset mid-frame, then release -> all outputs 0 immediately, no pulses; the next clean frame processes normally.

Source files
------------

// File: rtl/range_pkg.sv
// range_pkg
//   Shared definitions for the range sample framer.
//   - state_e   : framer state (IDLE, HIGH, LOW, FLUSH)
//   - BYTE_W    : stream byte width
//   - DEF_*     : default values for the framer parameters
package range_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNT_W   = 16;

  // HIGH means "waiting for the high byte of a sample".
  // LOW means "waiting for the low byte of the next sample".
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/range_idle_timer.sv
// range_idle_timer
//   Loadable down-counter that measures idle time between byte transfers.
//   Ports:
//     clock     in  clock, rising edge
//     reset     in  asynchronous active-high reset
//     run_i     in  count down while high (framer is inside a frame)
//     clear_i   in  a transfer happened: reload with TIMEOUT
//     expired_o out TIMEOUT idle cycles have elapsed while running
module range_idle_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Every entry into HIGH/LOW is through a transfer, which reloads the
  // counter, so the reset value of zero never causes a spurious expiry.
  assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/range_sample_framer.sv
// range_sample_framer
//   Assembles little-endian 16-bit samples from a framed byte stream and
//   drives the range finder's data/go/finish inputs. Framing faults and
//   idle timeouts inside a frame force the downstream stage into its error
//   state by pulsing go and finish together.
//   Ports:
//     clock, reset      clock (rising edge), asynchronous active-high reset
//     byte_in/valid     stream byte and its valid qualifier
//     byte_sof/eof      first/last byte of frame flags
//     byte_ready        framer accepts a byte this cycle (low only in FLUSH)
//     data_out          last assembled sample, held between samples
//     go / finish       first / last sample pulses; both together = abort
//     frame_err         one-cycle pulse on any framing fault
//     sample_count      samples emitted in the current/last frame, saturating
module range_sample_framer
  import range_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  input  logic              byte_sof,
  input  logic              byte_eof,
  output logic              byte_ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              go,
  output logic              finish,
  output logic              frame_err,
  output logic [CNT_W-1:0]  sample_count
);

  state_e            state_q;
  logic [BYTE_W-1:0] low_q;
  logic              first_q;
  logic [WIDTH-1:0]  data_q;
  logic              go_q;
  logic              finish_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              xfer;
  logic              expired;
  logic [CNT_W-1:0]  cnt_inc;

  assign byte_ready = (state_q != FLUSH);
  assign xfer       = byte_valid && byte_ready;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  range_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clock     (clock),
    .reset     (reset),
    .run_i     ((state_q == HIGH) || (state_q == LOW)),
    .clear_i   (xfer),
    .expired_o (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      low_q    <= '0;
      first_q  <= 1'b0;
      data_q   <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            if (byte_sof) begin
              low_q   <= byte_in;
              first_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= HIGH;
            end else begin
              err_q <= 1'b1;  // stray byte outside a frame is dropped
            end
          end
        end
        HIGH, LOW: begin
          if (xfer && byte_sof) begin
            // Abort the open frame and restart from this byte.
            err_q    <= 1'b1;
            go_q     <= 1'b1;
            finish_q <= 1'b1;
            low_q    <= byte_in;
            first_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= HIGH;
          end else if (xfer && (state_q == HIGH)) begin
            data_q <= WIDTH'({byte_in, low_q});
            cnt_q  <= cnt_inc;
            if (first_q) begin
              go_q    <= 1'b1;
              first_q <= 1'b0;
              // A one-sample frame defers finish by a cycle so go and
              // finish never coincide outside of an abort.
              state_q <= byte_eof ? FLUSH : LOW;
            end else if (byte_eof) begin
              finish_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              state_q <= LOW;
            end
          end else if (xfer) begin
            if (byte_eof) begin
              // Odd byte count: the lone low byte is never emitted.
              err_q    <= 1'b1;
              go_q     <= 1'b1;
              finish_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              low_q   <= byte_in;
              state_q <= HIGH;
            end
          end else if (expired) begin
            err_q    <= 1'b1;
            go_q     <= 1'b1;
            finish_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        FLUSH: begin
          finish_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out     = data_q;
  assign go           = go_q;
  assign finish       = finish_q;
  assign frame_err    = err_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_range_sample_framer.sv
module tb_range_sample_framer;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int W   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_sof;
  logic          byte_eof;
  logic          byte_ready;
  logic [W-1:0]  data_out;
  logic          go;
  logic          finish;
  logic          frame_err;
  logic [CW-1:0] sample_count;

  always #5 clock = ~clock;

  range_sample_framer #(
    .WIDTH   (W),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_sof     (byte_sof),
    .byte_eof     (byte_eof),
    .byte_ready   (byte_ready),
    .data_out     (data_out),
    .go           (go),
    .finish       (finish),
    .frame_err    (frame_err),
    .sample_count (sample_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model (frame-level view) ----------------
  logic [7:0]    fb[$];       // bytes of the currently open frame
  bit            in_frame;
  bit            flush_pend;  // one-sample frame owes a finish
  int            nsamp;
  int            idle;
  logic [W-1:0]  e_data;
  logic          e_go, e_fin, e_err, e_ready;
  logic [CW-1:0] e_cnt;

  task model_reset();
    fb.delete();
    in_frame = 0; flush_pend = 0; nsamp = 0; idle = 0;
    e_data = '0; e_go = 0; e_fin = 0; e_err = 0; e_ready = 1; e_cnt = '0;
  endtask

  task model_start(input logic [7:0] b);
    fb.delete();
    fb.push_back(b);
    in_frame = 1; idle = 0; nsamp = 0; e_cnt = '0;
  endtask

  task model_abort();
    e_err = 1; e_go = 1; e_fin = 1;
  endtask

  task model_step(input bit acc, input logic [7:0] b, input logic s, input logic e);
    e_go = 0; e_fin = 0; e_err = 0;
    if (flush_pend) begin
      e_fin = 1; flush_pend = 0; in_frame = 0;
    end else if (!in_frame) begin
      if (acc) begin
        if (s) model_start(b);
        else e_err = 1;
      end
    end else if (acc) begin
      idle = 0;
      if (s) begin
        model_abort();
        model_start(b);
      end else begin
        fb.push_back(b);
        if (fb.size() % 2 == 1) begin
          if (e) begin model_abort(); in_frame = 0; end
        end else begin
          e_data = {fb[fb.size()-1], fb[fb.size()-2]};
          nsamp++;
          e_cnt = CW'((nsamp > MAXC) ? MAXC : nsamp);
          if (nsamp == 1) e_go = 1;
          if (e) begin
            if (nsamp == 1) flush_pend = 1;
            else begin e_fin = 1; in_frame = 0; end
          end
        end
      end
    end else begin
      if (idle == TO) begin model_abort(); in_frame = 0; end
      else idle++;
    end
    e_ready = !flush_pend;
  endtask

  // ---------------- stimulus helpers ----------------
  task cycle(input logic v, input logic [7:0] b, input logic s, input logic e, output bit acc);
    byte_valid = v; byte_in = b; byte_sof = s; byte_eof = e;
    acc = v && e_ready;
    model_step(acc, b, s, e);
    @(posedge clock); #1;
    check("cycle", {40'd0, byte_ready, go, finish, frame_err, sample_count, data_out},
                   {40'd0, e_ready, e_go, e_fin, e_err, e_cnt, e_data});
  endtask

  task idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0, 1'b0, acc);
  endtask

  task send_byte(input logic [7:0] b, input logic s, input logic e);
    bit acc;
    int tries;
    acc = 0; tries = 0;
    while (!acc && tries < 8) begin
      cycle(1'b1, b, s, e, acc);
      tries++;
    end
    if (!acc) check("accept_bound", 64'(acc), 64'd1);
  endtask

  task send_frame(input string name, input logic [7:0] bytes[$]);
    for (int i = 0; i < bytes.size(); i++)
      send_byte(bytes[i], i == 0, i == bytes.size() - 1);
    $display("frame %s: %0d bytes, data_out=%h count=%0d", name, bytes.size(), data_out, sample_count);
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] q[$];
  bit acc;
  bit gen_in;

  initial begin
    byte_valid = 0; byte_in = 0; byte_sof = 0; byte_eof = 0;
    reset = 1;
    model_reset();
    @(posedge clock); #1;
    check("reset_state", {40'd0, byte_ready, go, finish, frame_err, sample_count, data_out},
                         {40'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0});
    @(posedge clock); #1;
    reset = 0;

    // Three-sample back-to-back frame
    q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    send_frame("three_sample", q);
    check("three_sample_data", 64'(data_out), 64'h9ABC);
    check("three_sample_count", 64'(sample_count), 64'd3);
    idle_cycles(2);

    // Single-sample frame: go, then finish with held data and ready low
    q = '{8'h01, 8'h00};
    send_frame("single_sample", q);
    check("single_go", {62'd0, go, byte_ready}, {62'd0, 1'b1, 1'b0});
    idle_cycles(1);
    check("single_finish", {45'd0, finish, byte_ready, go, data_out}, {45'd0, 1'b1, 1'b1, 1'b0, 16'h0001});
    idle_cycles(1);

    // sof in LOW after one sample: abort and restart
    send_byte(8'h11, 1, 0);
    send_byte(8'h22, 0, 0);
    send_byte(8'h33, 1, 0);
    check("restart_abort", {60'd0, go, finish, frame_err, 1'b0}, {60'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    check("restart_count", 64'(sample_count), 64'd0);
    send_byte(8'h44, 0, 0);
    check("restart_data", 64'(data_out), 64'h4433);
    send_byte(8'h55, 0, 0);
    send_byte(8'h66, 0, 1);
    $display("frame restart: data_out=%h count=%0d", data_out, sample_count);
    idle_cycles(2);

    // Odd byte count frame
    q = '{8'hA1, 8'hA2, 8'hA3};
    send_frame("odd_bytes", q);
    check("odd_data", 64'(data_out), 64'hA2A1);
    idle_cycles(2);

    // Timeout after a low byte, then a stray byte in IDLE
    send_byte(8'h10, 1, 0);
    send_byte(8'h20, 0, 0);
    send_byte(8'h30, 0, 0);
    idle_cycles(TO);
    check("no_early_timeout", 64'(frame_err), 64'd0);
    idle_cycles(1);
    check("timeout_abort", {61'd0, go, finish, frame_err}, {61'd0, 1'b1, 1'b1, 1'b1});
    send_byte(8'h77, 0, 0);
    check("stray_err", {61'd0, go, finish, frame_err}, {61'd0, 1'b0, 1'b0, 1'b1});
    $display("timeout/stray done");
    idle_cycles(1);

    // Reset mid-frame
    send_byte(8'h01, 1, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h03, 0, 0);
    reset = 1;
    #1;
    check("midframe_reset", {40'd0, byte_ready, go, finish, frame_err, sample_count, data_out},
                            {40'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0});
    model_reset();
    @(posedge clock); #1;
    reset = 0;
    idle_cycles(2);
    q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame("after_reset", q);
    check("after_reset_data", 64'(data_out), 64'hDEAD);
    idle_cycles(1);

    // Long frame: sample_count saturates
    q.delete();
    for (int i = 0; i < 2 * (MAXC + 3); i++) q.push_back(8'(i * 7 + 3));
    send_frame("long", q);
    check("count_saturates", 64'(sample_count), 64'(MAXC));
    idle_cycles(1);

    // Randomized traffic
    gen_in = 0;
    for (int c = 0; c < 4000; c++) begin
      logic v, s, e;
      logic [7:0] b;
      if ($urandom_range(0, 60) == 0) begin
        idle_cycles($urandom_range(TO, TO + 2));
        continue;
      end
      v = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
      s = gen_in ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 9) != 0);
      e = gen_in ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 20) == 0);
      cycle(v, b, s, e, acc);
      if (acc && s) gen_in = 1;
      if (acc && e) gen_in = 0;
    end
    $display("random phase done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
